// File: rtl/mem_interface.sv
// LC-3 memory subsystem: MAR/MDR, word-addressed RAM with programmable wait states,
// and memory-mapped keyboard/display registers; raises a one-cycle Ready for the sequencer.
module mem_interface #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter bit ENABLE_IO   = 1'b1
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_Bus,
  input  logic        i_LD_MAR,
  input  logic        i_LD_MDR,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  output logic        o_Ready,
  output logic [15:0] o_MDR,
  output logic [15:0] o_MAR,
  input  logic        i_KB_Valid,
  input  logic [7:0]  i_KB_Data,
  output logic        o_KB_Ready,
  output logic        o_DDR_Valid,
  output logic [7:0]  o_DDR_Data,
  input  logic        i_DDR_Ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] cap_addr;
  logic [15:0] cap_data;
  logic        cap_rw;
  logic        ready;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        kbsr;
  logic [7:0]  kbdr;
  logic        ddr_valid;
  logic [7:0]  ddr;
  logic [15:0] rdata;
  logic        io_hit;
  logic        rd_done;
  logic        wr_done;
  logic        kb_accept;

  logic [15:0] mem [2**ADDR_W];

  assign io_hit    = ENABLE_IO && (cap_addr[15:9] == 7'h7F);
  assign rd_done   = (state == DONE) && !cap_rw;
  assign wr_done   = (state == DONE) && cap_rw;
  assign kb_accept = i_KB_Valid && !kbsr;

  assign o_Ready     = ready;
  assign o_MDR       = mdr;
  assign o_MAR       = mar;
  assign o_KB_Ready  = !kbsr;
  assign o_DDR_Valid = ddr_valid;
  assign o_DDR_Data  = ddr;

  // Read data always comes from the address captured at the start of the access.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    rdata = '0;
    if (!io_hit) begin
      rdata = mem[cap_addr[ADDR_W-1:0]];
    end else begin
      case (cap_addr)
        16'hFE00: rdata = {kbsr, 15'b0};
        16'hFE02: rdata = {8'b0, kbdr};
        16'hFE04: rdata = {!ddr_valid, 15'b0};
        16'hFE06: rdata = {8'b0, ddr};
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_rw   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (i_MIO_EN) begin
            cap_addr <= mar;
            cap_data <= mdr;
            cap_rw   <= i_R_W;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= DONE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (i_LD_MAR) mar <= i_Bus;
      if (i_LD_MDR && !i_MIO_EN) mdr <= i_Bus;
      else if (i_LD_MDR && i_MIO_EN && rd_done) mdr <= rdata;
    end
  end

  // A KBDR read completing clears the full flag; the clear beats a new character.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      kbsr <= 1'b0;
      kbdr <= '0;
    end else begin
      if (rd_done && io_hit && cap_addr == 16'hFE02) kbsr <= 1'b0;
      else if (kb_accept) begin
        kbsr <= 1'b1;
        kbdr <= i_KB_Data;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      ddr_valid <= 1'b0;
      ddr       <= '0;
    end else begin
      if (wr_done && io_hit && cap_addr == 16'hFE06) begin
        ddr_valid <= 1'b1;
        ddr       <= cap_data[7:0];
      end else if (ddr_valid && i_DDR_Ready) begin
        ddr_valid <= 1'b0;
      end
    end
  end

  // NOTE: the RAM array has no reset; storage arrays are left uninitialised so they map to memory.
  always_ff @(posedge i_CLK) begin
    if (wr_done && !io_hit) mem[cap_addr[ADDR_W-1:0]] <= cap_data;
  end

endmodule
